// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch over a one-cycle registered imem read.
// Holds the word on stall, and a redirect restarts fetch at the new address.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_raddr,
    input  logic [31:0] imem_rdata,
    output logic        imem_wen,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    logic [31:0] pc_q, pc_d, hold_q, hold_d, target;
    logic        valid_q, valid_d, hold_valid_q, hold_valid_d;

    assign imem_wen   = 1'b0;
    assign imem_waddr = 32'd0;
    assign imem_wdata = 32'd0;

    always_comb begin
        target       = redirect_pc & ~32'd3;
        imem_raddr   = reset ? RESET_PC : redirect ? target : !valid_q ? pc_q : pc_q + 32'd4;
        pc_d         = (redirect || (valid_q && !stall)) ? imem_raddr : pc_q;
        valid_d      = 1'b1;
        // The first stalled cycle captures rdata; rdata then moves on to pc_q+4.
        hold_valid_d = !redirect && valid_q && stall;
        hold_d       = (hold_valid_d && !hold_valid_q) ? imem_rdata : hold_q;
        instr_valid  = valid_q && !redirect && !reset;
        instr        = hold_valid_q ? hold_q : imem_rdata;
        instr_pc     = pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with two instances (reset PC 0 and near wrap).
// Stimulus queues the expected delivered stream; a negedge monitor pops one entry per valid cycle.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, rst2, stall, redirect, zero;
    logic [31:0] redirect_pc;
    logic [31:0] raddr1, rdata1, waddr1, wdata1, instr1, pc1;
    logic [31:0] raddr2, rdata2, waddr2, wdata2, instr2, pc2;
    logic        wen1, wen2, iv1, iv2, wr_seen;
    logic [31:0] mem [256];
    logic [63:0] q1[$], q2[$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .reset(reset), .imem_raddr(raddr1), .imem_rdata(rdata1),
        .imem_wen(wen1), .imem_waddr(waddr1), .imem_wdata(wdata1),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(iv1), .instr(instr1), .instr_pc(pc1)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(rst2), .imem_raddr(raddr2), .imem_rdata(rdata2),
        .imem_wen(wen2), .imem_waddr(waddr2), .imem_wdata(wdata2),
        .stall(zero), .redirect(zero), .redirect_pc(32'd0),
        .instr_valid(iv2), .instr(instr2), .instr_pc(pc2)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_0193;
    end

    always @(posedge clk) begin
        rdata1 <= mem[8'(raddr1 >> 2)];
        rdata2 <= mem[8'(raddr2 >> 2)];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial wr_seen = 1'b0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (wen1 || wen2 || waddr1 != 0 || wdata1 != 0 || waddr2 != 0 || wdata2 != 0) wr_seen = 1'b1;
        if (iv1 === 1'b1) begin
            if (q1.size() == 0) chk("dut_unexpected_valid_pc", pc1, 32'hDEAD_DEAD);
            else begin
                e = q1.pop_front();
                chk("dut_pc", pc1, e[63:32]);
                chk("dut_instr", instr1, e[31:0]);
            end
        end
        if (iv2 === 1'b1) begin
            if (q2.size() == 0) chk("wrap_unexpected_valid_pc", pc2, 32'hDEAD_DEAD);
            else begin
                e = q2.pop_front();
                chk("wrap_pc", pc2, e[63:32]);
                chk("wrap_instr", instr2, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect = 1'b0; zero = 1'b0; redirect_pc = 32'd0;
        q1.push_back({32'h0, 32'h0000_0013});
        for (int i = 0; i < 4; i++) q1.push_back({32'h4, 32'h0010_0093});
        q1.push_back({32'hC, 32'h0030_0193});
        q1.push_back({32'h10, 32'hA000_0004});
        q1.push_back({32'h20, 32'hA000_0008});
        q1.push_back({32'h8, 32'h0020_0113});
        q1.push_back({32'h0, 32'h0000_0013});
        q1.push_back({32'h4, 32'h0010_0093});
        step(); step();
        @(negedge clk);
        chk("reset_valid", {31'd0, iv1}, 32'd0);
        chk("reset_raddr", raddr1, 32'h0);
        step(); reset = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", {31'd0, iv1}, 32'd0);
        chk("post_reset_raddr", raddr1, 32'h0);
        step();                                  // pc 0
        step(); stall = 1'b1;                    // pc 4, stalled for three cycles
        step(); step();
        step(); stall = 1'b0;                    // held word still presented
        step(); redirect = 1'b1; redirect_pc = 32'h0000_000E;
        @(negedge clk);
        chk("redirect_raddr", raddr1, 32'hC);
        chk("redirect_valid", {31'd0, iv1}, 32'd0);
        step(); redirect = 1'b0;                 // pc C
        step(); stall = 1'b1;                    // pc 10, capture into hold
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0020;
        @(negedge clk);
        chk("redir_stall_valid", {31'd0, iv1}, 32'd0);
        step(); redirect = 1'b0; stall = 1'b0;   // pc 20 from rdata, hold discarded
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0008;
        step(); redirect = 1'b0; stall = 1'b1;   // pc 8, stall
        step(); reset = 1'b1;
        @(negedge clk);
        chk("midstall_reset_valid", {31'd0, iv1}, 32'd0);
        chk("midstall_reset_raddr", raddr1, 32'h0);
        step(); reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("restart_valid", {31'd0, iv1}, 32'd0);
        chk("restart_raddr", raddr1, 32'h0);
        step(); step();                          // pc 0, pc 4
        step(); reset = 1'b1;
        step();
        q2.push_back({32'hFFFF_FFF8, 32'hA000_00FE});
        q2.push_back({32'hFFFF_FFFC, 32'hA000_00FF});
        q2.push_back({32'h0, 32'h0000_0013});
        q2.push_back({32'h4, 32'h0010_0093});
        step(); rst2 = 1'b0;
        @(negedge clk);
        chk("wrap_post_reset_valid", {31'd0, iv2}, 32'd0);
        chk("wrap_post_reset_raddr", raddr2, 32'hFFFF_FFF8);
        step(); step(); step(); step();
        step(); rst2 = 1'b1;
        step(); step();
        @(negedge clk);
        chk("dut_queue_left", q1.size(), 32'd0);
        chk("wrap_queue_left", q2.size(), 32'd0);
        chk("imem_write_seen", {31'd0, wr_seen}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
